// File: rtl/mul16_seq_pkg.sv
// mul16_seq_pkg: shared widths and FSM state encodings for the sequential multiplier.
package mul16_seq_pkg;
   localparam int WIDTH = 16;
   localparam int ITER  = WIDTH;
   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_RUN  = 2'd1;
   localparam logic [1:0] STATE_DONE = 2'd2;
endpackage

// File: rtl/mul16_seq_add16.sv
// add16: combinational 16-bit ripple-carry adder; carry-out is not exposed.
module add16
   import mul16_seq_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);
   logic c;
   always_comb begin
      c = 1'b0;
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
   end
endmodule

// File: rtl/mul16_seq.sv
// mul16_seq: shift-and-add 16x16 multiplier (low 16 bits) sequenced over one shared add16.
module mul16_seq
   import mul16_seq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   logic [1:0]       state_q, state_d;
   logic [3:0]       count_q, count_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] product_q, product_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] sum;
   logic             idle, run, fin, load;

   add16 u_add (.a(acc_q), .b(mcand_q), .sum(sum));

   always_comb begin
      idle = state_q == STATE_IDLE;
      run = state_q == STATE_RUN;
      fin = state_q == STATE_DONE;
      load = idle && start;
      state_d = load ? STATE_RUN
              : run ? (count_q == 4'(ITER - 1) ? STATE_DONE : STATE_RUN)
              : STATE_IDLE;
      mcand_d = load ? a : run ? mcand_q << 1 : mcand_q;
      mplier_d = load ? b : run ? mplier_q >> 1 : mplier_q;
      acc_d = load ? '0 : (run && mplier_q[0]) ? sum : acc_q;
      count_d = load ? 4'd0 : run ? 4'(count_q + 4'd1) : count_q;
      product_d = fin ? acc_q : product_q;
      done_d = fin;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= STATE_IDLE;
         count_q <= '0;
         mcand_q <= '0;
         mplier_q <= '0;
         acc_q <= '0;
         product_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mcand_q <= mcand_d;
         mplier_q <= mplier_d;
         acc_q <= acc_d;
         product_q <= product_d;
         done_q <= done_d;
      end
   end

   assign busy = state_q != STATE_IDLE;
   assign done = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: table-driven and directed checks of mul16_seq latency, wrap-around and handshake.
module tb_mul16_seq;
   logic        clock, reset, start;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] product;
   int          errors = 0;
   int          checks = 0;
   int          pulses;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] p;
   } vec_t;
   vec_t vecs [10];

   mul16_seq dut (
      .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_mul(input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp, input string name);
      int n;
      a = x;
      b = y;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = ~x;
      b = ~y;
      chk({name, " busy_after_start"}, busy, 1);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk({name, " latency"}, n, 17);
      chk({name, " product"}, product, exp);
      chk({name, " busy_at_done"}, busy, 0);
      tick();
      chk({name, " done_one_cycle"}, done, 0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      vecs[0] = '{16'd3, 16'd5, 16'h000F};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 16'h0001};
      vecs[2] = '{16'h0100, 16'h0100, 16'h0000};
      vecs[3] = '{16'h1234, 16'h0000, 16'h0000};
      vecs[4] = '{16'd7, 16'd6, 16'h002A};
      vecs[5] = '{16'hFFFF, 16'd2, 16'hFFFE};
      vecs[6] = '{16'h8000, 16'd2, 16'h0000};
      vecs[7] = '{16'h00FF, 16'h0101, 16'hFFFF};
      vecs[8] = '{16'h1234, 16'd1, 16'h1234};
      vecs[9] = '{16'd12, 16'd12, 16'h0090};

      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      tick();
      tick();
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset product", product, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) run_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

      // Starts during RUN and in the DONE cycle must be dropped
      a = 16'd7;
      b = 16'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      a = 16'd9;
      b = 16'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      chk("ignore busy_in_done", busy, 1);
      chk("ignore no_early_done", done, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ignore done", done, 1);
      chk("ignore product", product, 16'h002A);
      pulses = 0;
      repeat (20) begin
         tick();
         if (done) pulses++;
      end
      chk("ignore no_second_done", pulses, 0);
      run_mul(16'd9, 16'd9, 16'h0051, "after_ignore");

      // Reset mid-operation discards the partial result
      a = 16'd100;
      b = 16'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset busy", busy, 0);
      chk("midreset done", done, 0);
      chk("midreset product", product, 0);
      pulses = 0;
      repeat (25) begin
         tick();
         if (done) pulses++;
      end
      chk("midreset no_done", pulses, 0);
      run_mul(16'd2, 16'd3, 16'h0006, "after_reset");

      for (int i = 0; i < 20; i++) begin
         tick();
         chk("hold product", product, 16'h0006);
      end

      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_mul(ra, rb, 16'((32'(ra) * 32'(rb)) & 32'hFFFF), $sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
